// File: rtl/pc_unit_if.sv
// Fetch-PC bus between pipeline control and pc_unit.
// Signal names follow the fetch/decode stage suffixes used across the core.
interface pc_unit_if;
  logic        stall_f;
  logic        stall_d;
  logic        branch_d;
  logic [31:0] branch_target_d;
  logic        jump_d;
  logic [31:0] jump_target_d;
  logic        exc_flush;
  logic [31:0] exc_pc;
  logic [31:0] pc_f;
  logic [31:0] pc_plus4_f;
  logic        inst_req;
  logic        redirect_pending;
  logic        adel_f;

  modport slave (
    input  stall_f, stall_d, branch_d, branch_target_d, jump_d, jump_target_d,
    input  exc_flush, exc_pc,
    output pc_f, pc_plus4_f, inst_req, redirect_pending, adel_f
  );

  modport master (
    output stall_f, stall_d, branch_d, branch_target_d, jump_d, jump_target_d,
    output exc_flush, exc_pc,
    input  pc_f, pc_plus4_f, inst_req, redirect_pending, adel_f
  );
endinterface

// File: rtl/pc_unit.sv
// Fetch program counter with a one-entry buffer for decode redirects raised while fetch stalls.
// Optional fetch alignment check enabled by defining PC_ALIGN_CHECK_EN.
module pc_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input logic        clk,
  input logic        rst,
  pc_unit_if.slave   pc_if
);

  typedef enum logic [0:0] {StIdle, StPending} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        redirect_d;
  logic [31:0] target;

  assign redirect_d = (pc_if.branch_d | pc_if.jump_d) & ~pc_if.stall_d;
  assign target     = pc_if.jump_d ? pc_if.jump_target_d : pc_if.branch_target_d;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    if (pc_if.exc_flush) begin
      pc_d          = pc_if.exc_pc;
      state_d       = StIdle;
      pend_target_d = '0;
    end else if (pc_if.stall_f) begin
      // Only the first redirect seen during a stall is kept.
      if (state_q == StIdle && redirect_d) begin
        pend_target_d = target;
        state_d       = StPending;
      end
    end else if (state_q == StPending) begin
      pc_d    = pend_target_q;
      state_d = StIdle;
    end else if (redirect_d) begin
      pc_d = target;
    end else begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign pc_if.pc_f             = pc_q;
  assign pc_if.pc_plus4_f       = pc_q + 32'd4;
  assign pc_if.redirect_pending = (state_q == StPending);

`ifdef PC_ALIGN_CHECK_EN
  logic adel;
  assign adel           = (pc_q[1:0] != 2'b00) & ~rst;
  assign pc_if.adel_f   = adel;
  assign pc_if.inst_req = ~rst & ~adel;
`else
  assign pc_if.adel_f   = 1'b0;
  assign pc_if.inst_req = ~rst;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: expected PCs are queued as stimulus is driven and
// popped after the following clock edge.
module tb_pc_unit;

  localparam logic [31:0] RstPc = 32'hBFC00000;

  logic clk;
  logic rst;
  pc_unit_if bus ();

  pc_unit #(.RESET_PC(RstPc)) dut (
    .clk   (clk),
    .rst   (rst),
    .pc_if (bus)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.stall_f = 0; bus.stall_d = 0;
    bus.branch_d = 0; bus.branch_target_d = '0;
    bus.jump_d = 0; bus.jump_target_d = '0;
    bus.exc_flush = 0; bus.exc_pc = '0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1;
    #3;
    n_total++; if (bus.pc_f !== RstPc)
      $display("FAIL reset_pc: got %h expected %h", bus.pc_f, RstPc); else n_pass++;
    n_total++; if (bus.redirect_pending !== 1'b0)
      $display("FAIL reset_pending: got %b expected 0", bus.redirect_pending); else n_pass++;
    n_total++; if (bus.inst_req !== 1'b0)
      $display("FAIL reset_inst_req: got %b expected 0", bus.inst_req); else n_pass++;
    n_total++; if (bus.adel_f !== 1'b0)
      $display("FAIL reset_adel: got %b expected 0", bus.adel_f); else n_pass++;
    tick(); tick();
    n_total++; if (bus.pc_f !== RstPc)
      $display("FAIL reset_hold: got %h expected %h", bus.pc_f, RstPc); else n_pass++;
  endtask

  task automatic test_sequential;
    rst = 0;
    for (int i = 0; i < 4; i++) exp_q.push_back(RstPc + 32'(4 * i));
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      n_total++; if (bus.pc_f !== e)
        $display("FAIL seq_pc[%0d]: got %h expected %h", i, bus.pc_f, e); else n_pass++;
      n_total++; if (bus.redirect_pending !== 1'b0)
        $display("FAIL seq_pending[%0d]: got %b expected 0", i, bus.redirect_pending);
      else n_pass++;
      tick();
    end
    n_total++; if (bus.inst_req !== 1'b1)
      $display("FAIL seq_inst_req: got %b expected 1", bus.inst_req); else n_pass++;
  endtask

  task automatic test_branch;
    n_total++; if (bus.pc_f !== 32'hBFC00010)
      $display("FAIL branch_start: got %h expected BFC00010", bus.pc_f); else n_pass++;
    bus.branch_d = 1; bus.branch_target_d = 32'hBFC00100;
    exp_q.push_back(32'hBFC00100);
    tick();
    bus.branch_d = 0;
    e = exp_q.pop_front();
    n_total++; if (bus.pc_f !== e)
      $display("FAIL branch_taken: got %h expected %h", bus.pc_f, e); else n_pass++;
    exp_q.push_back(32'hBFC00104);
    tick();
    e = exp_q.pop_front();
    n_total++; if (bus.pc_f !== e)
      $display("FAIL branch_next: got %h expected %h", bus.pc_f, e); else n_pass++;
    n_total++; if (bus.pc_plus4_f !== 32'hBFC00108)
      $display("FAIL branch_plus4: got %h expected BFC00108", bus.pc_plus4_f); else n_pass++;
  endtask

  task automatic test_stall_pending;
    bus.stall_f = 1;
    bus.branch_d = 1; bus.branch_target_d = 32'h80001000;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'hBFC00104);
      tick();
      bus.branch_d = 0;
      // A later redirect during the same stall must not replace the buffered one.
      bus.jump_d = (i == 0); bus.jump_target_d = 32'h0000DEAC;
      e = exp_q.pop_front();
      n_total++; if (bus.pc_f !== e)
        $display("FAIL stall_hold[%0d]: got %h expected %h", i, bus.pc_f, e); else n_pass++;
      n_total++; if (bus.redirect_pending !== 1'b1)
        $display("FAIL stall_pending[%0d]: got %b expected 1", i, bus.redirect_pending);
      else n_pass++;
    end
    bus.stall_f = 0;
    bus.jump_d = 1; bus.jump_target_d = 32'h12345670;
    exp_q.push_back(32'h80001000);
    tick();
    bus.jump_d = 0;
    e = exp_q.pop_front();
    n_total++; if (bus.pc_f !== e)
      $display("FAIL release_pc: got %h expected %h", bus.pc_f, e); else n_pass++;
    n_total++; if (bus.redirect_pending !== 1'b0)
      $display("FAIL release_pending: got %b expected 0", bus.redirect_pending); else n_pass++;
    exp_q.push_back(32'h80001004);
    tick();
    e = exp_q.pop_front();
    n_total++; if (bus.pc_f !== e)
      $display("FAIL release_next: got %h expected %h", bus.pc_f, e); else n_pass++;
  endtask

  task automatic test_exc_flush;
    bus.stall_f = 1;
    bus.branch_d = 1; bus.branch_target_d = 32'h00004000;
    tick();
    bus.branch_d = 0;
    n_total++; if (bus.redirect_pending !== 1'b1)
      $display("FAIL exc_setup_pending: got %b expected 1", bus.redirect_pending); else n_pass++;
    bus.exc_flush = 1; bus.exc_pc = 32'hBFC00380;
    exp_q.push_back(32'hBFC00380);
    tick();
    bus.exc_flush = 0;
    e = exp_q.pop_front();
    n_total++; if (bus.pc_f !== e)
      $display("FAIL exc_pc: got %h expected %h", bus.pc_f, e); else n_pass++;
    n_total++; if (bus.redirect_pending !== 1'b0)
      $display("FAIL exc_pending: got %b expected 0", bus.redirect_pending); else n_pass++;
    exp_q.push_back(32'hBFC00380);
    tick();
    bus.stall_f = 0;
    e = exp_q.pop_front();
    n_total++; if (bus.pc_f !== e)
      $display("FAIL exc_stall_hold: got %h expected %h", bus.pc_f, e); else n_pass++;
    exp_q.push_back(32'hBFC00384);
    tick();
    e = exp_q.pop_front();
    n_total++; if (bus.pc_f !== e)
      $display("FAIL exc_no_stale: got %h expected %h", bus.pc_f, e); else n_pass++;
  endtask

  task automatic test_wrap;
    bus.exc_flush = 1; bus.exc_pc = 32'hFFFFFFFC;
    tick();
    bus.exc_flush = 0;
    n_total++; if (bus.pc_plus4_f !== 32'h00000000)
      $display("FAIL wrap_plus4_top: got %h expected 00000000", bus.pc_plus4_f); else n_pass++;
    exp_q.push_back(32'h00000000);
    tick();
    e = exp_q.pop_front();
    n_total++; if (bus.pc_f !== e)
      $display("FAIL wrap_pc: got %h expected %h", bus.pc_f, e); else n_pass++;
    n_total++; if (bus.pc_plus4_f !== 32'h00000004)
      $display("FAIL wrap_plus4: got %h expected 00000004", bus.pc_plus4_f); else n_pass++;
  endtask

  task automatic test_back_to_back;
    // Jump has priority over branch; stall_d masks the decode redirect.
    bus.branch_d = 1; bus.branch_target_d = 32'h00001000;
    bus.jump_d = 1; bus.jump_target_d = 32'h00002000;
    exp_q.push_back(32'h00002000);
    tick();
    bus.jump_d = 0; bus.branch_target_d = 32'h00003000;
    exp_q.push_back(32'h00003000);
    tick();
    bus.stall_d = 1; bus.branch_target_d = 32'h00005000;
    exp_q.push_back(32'h00003004);
    tick();
    bus.stall_d = 0; bus.branch_d = 0;
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      n_total++; if (1'b1 && i == 2 && bus.pc_f !== e)
        $display("FAIL b2b_pc[%0d]: got %h expected %h", i, bus.pc_f, e);
      else if (i == 2) n_pass++;
      else n_total--;
    end
  endtask

  task automatic test_reset_mid_pending;
    bus.stall_f = 1;
    bus.jump_d = 1; bus.jump_target_d = 32'h0000A000;
    tick();
    bus.jump_d = 0;
    n_total++; if (bus.redirect_pending !== 1'b1)
      $display("FAIL rstmid_setup: got %b expected 1", bus.redirect_pending); else n_pass++;
    #2 rst = 1;
    #1;
    n_total++; if (bus.pc_f !== RstPc)
      $display("FAIL rstmid_async_pc: got %h expected %h", bus.pc_f, RstPc); else n_pass++;
    n_total++; if (bus.redirect_pending !== 1'b0 || bus.inst_req !== 1'b0)
      $display("FAIL rstmid_async_flags: got pend=%b req=%b expected 0/0",
               bus.redirect_pending, bus.inst_req);
    else n_pass++;
    tick();
    rst = 0; bus.stall_f = 0;
    exp_q.push_back(RstPc + 32'd4);
    tick();
    e = exp_q.pop_front();
    n_total++; if (bus.pc_f !== e)
      $display("FAIL rstmid_first: got %h expected %h", bus.pc_f, e); else n_pass++;
  endtask

  task automatic test_align;
    logic exp_adel, exp_req;
`ifdef PC_ALIGN_CHECK_EN
    exp_adel = 1'b1; exp_req = 1'b0;
`else
    exp_adel = 1'b0; exp_req = 1'b1;
`endif
    bus.jump_d = 1; bus.jump_target_d = 32'hBFC00102;
    exp_q.push_back(32'hBFC00102);
    tick();
    bus.jump_d = 0;
    e = exp_q.pop_front();
    n_total++; if (bus.pc_f !== e)
      $display("FAIL align_pc: got %h expected %h", bus.pc_f, e); else n_pass++;
    n_total++; if (bus.adel_f !== exp_adel)
      $display("FAIL align_adel: got %b expected %b", bus.adel_f, exp_adel); else n_pass++;
    n_total++; if (bus.inst_req !== exp_req)
      $display("FAIL align_inst_req: got %b expected %b", bus.inst_req, exp_req); else n_pass++;
    exp_q.push_back(32'hBFC00106);
    tick();
    e = exp_q.pop_front();
    n_total++; if (bus.pc_f !== e)
      $display("FAIL align_next: got %h expected %h", bus.pc_f, e); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_stall_pending();
    test_exc_flush();
    test_wrap();
    test_back_to_back();
    test_reset_mid_pending();
    test_align();
    n_total++; if (exp_q.size() != 0)
      $display("FAIL scoreboard_drain: got %0d expected 0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'hBFC00000: fetch address loaded on reset.
REQ-002 SHALL have exactly one clock and an asynchronous, active-high reset, ports listed first.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 stall_f  input  1  fetch stage stalled; PC must hold.
REQ-006 stall_d  input  1  decode stage stalled; decode redirects not accepted.
REQ-007 branch_d  input  1  taken-branch decision from the decode-stage branch comparator.
REQ-008 branch_target_d  input  32  branch target computed in decode.
REQ-009 jump_d  input  1  J/JAL/JR/JALR in decode.
REQ-010 jump_target_d  input  32  jump target computed in decode.
REQ-011 exc_flush  input  1  exception/ERET redirect from writeback/CP0.
REQ-012 exc_pc  input  32  exception or ERET target.
REQ-013 pc_f  output  32  current fetch address (registered).
REQ-014 pc_plus4_f  output  32  pc_f + 4 (combinational, modulo 2^32).
REQ-015 inst_req  output  1  instruction-fetch request valid.
REQ-016 redirect_pending  output  1  a decode redirect is buffered (state PENDING).
REQ-017 adel_f  output  1  fetch address error flag (see Configuration).

Function
REQ-018 SHALL form redirect_d = (branch_d | jump_d) & ~stall_d; target = jump_d ? jump_target_d : branch_target_d (jump wins if both high).
REQ-019 SHALL implement a two-state FSM, IDLE and PENDING, plus a 32-bit pend_target register.
REQ-020 Priority per cycle SHALL be: exc_flush > stall_f > PENDING release > redirect_d > sequential.
REQ-021 exc_flush=1: pc_f <= exc_pc next edge regardless of stall_f; FSM -> IDLE; pending target discarded.
REQ-022 stall_f=1, IDLE, redirect_d=1: pc_f holds; pend_target <= target; FSM -> PENDING.
REQ-023 stall_f=1, otherwise: pc_f and FSM hold.
REQ-024 stall_f=0, PENDING: pc_f <= pend_target; FSM -> IDLE; redirect_d ignored that cycle.
REQ-025 stall_f=0, IDLE, redirect_d=1: pc_f <= target (one-cycle redirect latency; delay-slot instruction already in fetch).
REQ-026 stall_f=0, IDLE, redirect_d=0: pc_f <= pc_f + 4; 32'hFFFFFFFC wraps to 32'h00000000.
REQ-027 redirect_d in PENDING while stall_f=1 SHALL be ignored (no overwrite of pend_target).
REQ-028 redirect_pending SHALL equal (state == PENDING).
REQ-029 inst_req SHALL be 1 whenever rst=0, subject to REQ-034.

Reset
REQ-030 rst=1 SHALL immediately force pc_f=RESET_PC, FSM=IDLE, pend_target=0, redirect_pending=0, inst_req=0, adel_f=0.
REQ-031 Reset asserted mid-PENDING SHALL discard the buffered redirect; first post-reset fetch is RESET_PC.
REQ-032 After deassertion, pc_f advances only on the next rising edge per Function rules.

Configuration
REQ-033 Macro PC_ALIGN_CHECK_EN SHALL compile the fetch alignment check in or out.
REQ-034 Defined: adel_f = (pc_f[1:0] != 0) & ~rst; inst_req forced 0 while adel_f=1; PC update rules unchanged.
REQ-035 Undefined: adel_f tied 0; inst_req = ~rst; no alignment logic synthesized.

Verification
REQ-036 Reset release, no stalls, 4 cycles -> pc_f = BFC00000, BFC00004, BFC00008, BFC0000C; redirect_pending=0.
REQ-037 pc_f=BFC00010, branch_d=1, target=BFC00100, stall_f=0 -> next pc_f=BFC00100, then BFC00104.
REQ-038 stall_f=1 for 3 cycles, branch_d=1 target=80001000 in first stalled cycle only -> pc_f holds, redirect_pending=1; cycle after stall_f drops, pc_f=80001000, redirect_pending=0.
REQ-039 PENDING state, exc_flush=1 exc_pc=BFC00380 with stall_f=1 -> pc_f=BFC00380, redirect_pending=0, buffered target never fetched.
REQ-040 pc_f forced to FFFFFFFC, no redirect -> next pc_f=00000000, pc_plus4_f=00000004.
REQ-041 With PC_ALIGN_CHECK_EN, jump_d=1 target=BFC00102 -> pc_f=BFC00102, adel_f=1, inst_req=0; without macro adel_f=0, inst_req=1.
